// File: rtl/r_slave_arbiter.sv
// r_slave_arbiter: round-robin merge of several AXI R channels into one response buffer.
// Define R_ARB_BURST_LOCK_EN to hold the grant for a whole burst; otherwise beats interleave.
module r_slave_arbiter #(
  parameter int NUM_SLAVES = 4,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2,
  localparam int IDX_W     = $clog2(NUM_SLAVES)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_SLAVES-1:0]            s_valid,
  output logic [NUM_SLAVES-1:0]            s_ready,
  input  logic [NUM_SLAVES*ID_WIDTH-1:0]   s_id,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_SLAVES*RESP_WIDTH-1:0] s_resp,
  input  logic [NUM_SLAVES-1:0]            s_last,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [ID_WIDTH-1:0]              m_id,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic [RESP_WIDTH-1:0]            m_resp,
  output logic                             m_last,
  output logic [IDX_W-1:0]                 m_src,
  input  logic                             buf_full,
  output logic                             burst_active,
  output logic [IDX_W-1:0]                 lock_idx
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state, state_d;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0] rr_sel;
  logic [IDX_W-1:0] sel;
  logic             rr_found;
  logic             grant_ok;
  logic             fire;
  int               cand;

  // Increment modulo NUM_SLAVES so non-power-of-2 counts never alias onto a missing slave.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
    if (x == IDX_W'(NUM_SLAVES - 1)) return '0;
    else return x + 1'b1;
  endfunction

  // First valid slave at or after rr_ptr, searching circularly.
  always_comb begin
    rr_sel   = rr_ptr;
    rr_found = 1'b0;
    cand     = 0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_SLAVES) cand = cand - NUM_SLAVES;
      if (!rr_found && s_valid[IDX_W'(cand)]) begin
        rr_found = 1'b1;
        rr_sel   = IDX_W'(cand);
      end
    end
  end

  assign sel = (state == LOCKED) ? lock_idx_q : rr_sel;

  assign m_id   = s_id[int'(sel)*ID_WIDTH +: ID_WIDTH];
  assign m_data = s_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  assign m_resp = s_resp[int'(sel)*RESP_WIDTH +: RESP_WIDTH];
  assign m_last = s_last[sel];
  assign m_src  = sel;

  assign grant_ok = ~rst & m_ready & ~buf_full;
  assign m_valid  = ~rst & s_valid[sel] & ~buf_full;
  assign fire     = m_valid & m_ready;

  // Handshake: a beat moves when the selected slave's valid and ready are both high in the
  // same cycle; m_valid/m_ready mirror that toward the buffer and never wait on each other.
  always_comb begin
    s_ready = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (IDX_W'(i) == sel) s_ready[i] = grant_ok & ((state == LOCKED) | s_valid[i]);
    end
  end

  always_comb begin
    state_d    = state;
    rr_ptr_d   = rr_ptr;
    lock_idx_d = lock_idx_q;
    case (state)
      IDLE: begin
        if (fire) begin
`ifdef R_ARB_BURST_LOCK_EN
          if (!m_last) begin
            state_d    = LOCKED;
            lock_idx_d = sel;
          end else begin
            rr_ptr_d = wrap_inc(sel);
          end
`else
          rr_ptr_d = wrap_inc(sel);
`endif
        end
      end
      LOCKED: begin
        if (fire && m_last) begin
          state_d  = IDLE;
          rr_ptr_d = wrap_inc(lock_idx_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      lock_idx_q <= '0;
    end else begin
      state      <= state_d;
      rr_ptr     <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

`ifdef R_ARB_BURST_LOCK_EN
  assign burst_active = (state == LOCKED);
`else
  assign burst_active = 1'b0;
`endif
  assign lock_idx = (state == LOCKED) ? lock_idx_q : '0;

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(s_ready));
  a_fire_ready:   assert property (@(posedge clk) disable iff (rst) fire |-> s_ready[sel]);
`endif

endmodule

// File: tb/tb_r_slave_arbiter.sv
// Bench for r_slave_arbiter: per-slave beat sources, expected-beat queue, per-scenario checks.
module tb_r_slave_arbiter;
  localparam int NS = 4;
  localparam int IW = 4;
  localparam int DW = 64;
  localparam int RW = 2;
  localparam int XW = $clog2(NS);
  localparam int EW = XW + IW + RW + 1 + DW;

  logic           clk = 1'b0;
  logic           rst;
  logic [NS-1:0]  s_valid, s_ready, s_last;
  logic [NS*IW-1:0] s_id;
  logic [NS*DW-1:0] s_data;
  logic [NS*RW-1:0] s_resp;
  logic           m_valid, m_ready, m_last, buf_full, burst_active;
  logic [IW-1:0]  m_id;
  logic [DW-1:0]  m_data;
  logic [RW-1:0]  m_resp;
  logic [XW-1:0]  m_src, lock_idx;

  r_slave_arbiter #(.NUM_SLAVES(NS), .ID_WIDTH(IW), .DATA_WIDTH(DW), .RESP_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_id(s_id), .s_data(s_data),
    .s_resp(s_resp), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_id(m_id),
    .m_data(m_data), .m_resp(m_resp), .m_last(m_last), .m_src(m_src), .buf_full(buf_full),
    .burst_active(burst_active), .lock_idx(lock_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_b;

  int   beat_cnt[NS];
  int   beat_ptr[NS];
  logic beat_last_a[NS][32];

  logic          obs_valid, obs_fire, obs_ba;
  logic [NS-1:0] obs_ready;
  logic [XW-1:0] obs_lock;
  logic [DW-1:0] obs_data;
  logic [EW-1:0] obs_beat;

  function automatic logic [DW-1:0] beat_data(int i, int k);
    return 64'hD00D_0000_0000_0000 | (64'(i) << 16) | 64'(k);
  endfunction

  function automatic logic [EW-1:0] exp_beat(int i, int k);
    return {XW'(i), IW'(i ^ 10), RW'(i), beat_last_a[i][k], beat_data(i, k)};
  endfunction

  task automatic clear_beats();
    for (int i = 0; i < NS; i++) begin
      beat_cnt[i] = 0;
      beat_ptr[i] = 0;
    end
  endtask

  task automatic add_burst(int i, int len);
    for (int k = 0; k < len; k++) begin
      beat_last_a[i][beat_cnt[i]] = (k == len - 1);
      beat_cnt[i]++;
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NS; i++) begin
      s_id[i*IW +: IW]   = IW'(i ^ 10);
      s_resp[i*RW +: RW] = RW'(i);
      if (beat_ptr[i] < beat_cnt[i]) begin
        s_valid[i]         = 1'b1;
        s_data[i*DW +: DW] = beat_data(i, beat_ptr[i]);
        s_last[i]          = beat_last_a[i][beat_ptr[i]];
      end else begin
        s_valid[i]         = 1'b0;
        s_data[i*DW +: DW] = '0;
        s_last[i]          = 1'b0;
      end
    end
  endtask

  // One clock: drive, sample at the falling edge, retire accepted beats after the rising edge.
  task automatic step();
    drive_inputs();
    @(negedge clk);
    obs_valid = m_valid;
    obs_fire  = m_valid & m_ready;
    obs_ready = s_ready;
    obs_ba    = burst_active;
    obs_lock  = lock_idx;
    obs_data  = m_data;
    obs_beat  = {m_src, m_id, m_resp, m_last, m_data};
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) if (s_valid[i] && obs_ready[i]) beat_ptr[i]++;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_ready = 1'b1; buf_full = 1'b0;
    clear_beats();
    for (int i = 0; i < NS; i++) add_burst(i, 1);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (obs_valid !== 1'b0 || obs_ready !== '0 || obs_ba !== 1'b0 || obs_lock !== '0) begin
        errors++;
        $display("FAIL reset_hold got valid=%b ready=%b ba=%b lock=%0d want 0 0000 0 0",
                 obs_valid, obs_ready, obs_ba, obs_lock);
      end
    end
    clear_beats();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (obs_valid !== 1'b0 || obs_ready !== '0 || obs_ba !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle got valid=%b ready=%b ba=%b want 0 0000 0",
                 obs_valid, obs_ready, obs_ba);
      end
    end
  endtask

  task automatic test_round_robin();
    clear_beats();
    for (int r = 0; r < 2; r++) for (int i = 0; i < NS; i++) add_burst(i, 1);
    for (int r = 0; r < 2; r++) for (int i = 0; i < NS; i++) exp_q.push_back(exp_beat(i, r));
    for (int c = 0; c < 2 * NS; c++) begin
      step();
      checks++;
      if (obs_fire !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL rr_fire cycle %0d got %b want 1", c, obs_fire);
      end else begin
        exp_b = exp_q.pop_front();
        if (obs_beat !== exp_b) begin
          errors++;
          $display("FAIL rr_beat cycle %0d got %h want %h", c, obs_beat, exp_b);
        end
      end
    end
  endtask

  task automatic test_m_ready_stall();
    int n;
    clear_beats();
    add_burst(2, 1);
    exp_q.push_back(exp_beat(2, 0));
    m_ready = 1'b0;
    n = $urandom_range(1, 3);
    for (int c = 0; c < n; c++) begin
      step();
      checks++;
      if (obs_valid !== 1'b1 || obs_ready !== '0 || obs_beat !== exp_q[0]) begin
        errors++;
        $display("FAIL stall_hold got valid=%b ready=%b beat=%h want 1 0000 %h",
                 obs_valid, obs_ready, obs_beat, exp_q[0]);
      end
    end
    m_ready = 1'b1;
    step();
    checks++;
    exp_b = exp_q.pop_front();
    if (obs_fire !== 1'b1 || obs_ready !== 4'b0100 || obs_beat !== exp_b) begin
      errors++;
      $display("FAIL stall_release got fire=%b ready=%b beat=%h want 1 0100 %h",
               obs_fire, obs_ready, obs_beat, exp_b);
    end
  endtask

`ifdef R_ARB_BURST_LOCK_EN
  task automatic test_burst_lock();
    int src_seq[6] = '{1, 1, 1, 1, 2, 2};
    int idx_seq[6] = '{0, 1, 2, 3, 0, 1};
    clear_beats();
    add_burst(1, 4);
    add_burst(2, 1);
    add_burst(2, 1);
    for (int c = 0; c < 6; c++) exp_q.push_back(exp_beat(src_seq[c], idx_seq[c]));
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (obs_fire !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL lock_fire cycle %0d got %b want 1", c, obs_fire);
      end else begin
        exp_b = exp_q.pop_front();
        if (obs_beat !== exp_b) begin
          errors++;
          $display("FAIL lock_beat cycle %0d got %h want %h", c, obs_beat, exp_b);
        end
      end
      checks++;
      if (obs_ba !== (c >= 1 && c <= 3) || obs_lock !== ((c >= 1 && c <= 3) ? XW'(1) : XW'(0))) begin
        errors++;
        $display("FAIL lock_state cycle %0d got ba=%b lock=%0d", c, obs_ba, obs_lock);
      end
    end
  endtask

  task automatic test_buf_full();
    int src_seq[5] = '{1, 1, 1, 1, 2};
    int idx_seq[5] = '{0, 1, 2, 3, 0};
    clear_beats();
    add_burst(1, 4);
    add_burst(2, 1);
    for (int c = 0; c < 5; c++) exp_q.push_back(exp_beat(src_seq[c], idx_seq[c]));
    for (int c = 0; c < 7; c++) begin
      buf_full = (c == 2 || c == 3);
      step();
      checks++;
      if (buf_full) begin
        if (obs_valid !== 1'b0 || obs_ready !== '0 || obs_ba !== 1'b1 || obs_lock !== XW'(1) ||
            obs_data !== beat_data(1, 2)) begin
          errors++;
          $display("FAIL full_hold cycle %0d got valid=%b ready=%b ba=%b lock=%0d data=%h want 0 0000 1 1 %h",
                   c, obs_valid, obs_ready, obs_ba, obs_lock, obs_data, beat_data(1, 2));
        end
      end else if (obs_fire !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL full_fire cycle %0d got %b want 1", c, obs_fire);
      end else begin
        exp_b = exp_q.pop_front();
        if (obs_beat !== exp_b || obs_ba !== (c >= 1 && c <= 5)) begin
          errors++;
          $display("FAIL full_beat cycle %0d got %h ba=%b want %h", c, obs_beat, obs_ba, exp_b);
        end
      end
    end
    buf_full = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int src_seq[4] = '{1, 2, 3, 3};
    int idx_seq[4] = '{0, 0, 2, 3};
    clear_beats();
    add_burst(3, 4);
    add_burst(1, 1);
    add_burst(2, 1);
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (obs_fire !== 1'b1 || obs_beat !== exp_beat(3, c)) begin
        errors++;
        $display("FAIL rmb_pre cycle %0d got %h want %h", c, obs_beat, exp_beat(3, c));
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== '0 || burst_active !== 1'b0 || lock_idx !== '0) begin
      errors++;
      $display("FAIL rmb_in_reset got valid=%b ready=%b ba=%b lock=%0d want 0 0000 0 0",
               m_valid, s_ready, burst_active, lock_idx);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) exp_q.push_back(exp_beat(src_seq[c], idx_seq[c]));
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (obs_fire !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL rmb_fire cycle %0d got %b want 1", c, obs_fire);
      end else begin
        exp_b = exp_q.pop_front();
        if (obs_beat !== exp_b || obs_ba !== (c == 3)) begin
          errors++;
          $display("FAIL rmb_beat cycle %0d got %h ba=%b want %h ba=%b", c, obs_beat, obs_ba, exp_b, c == 3);
        end
      end
    end
  endtask
`else
  task automatic test_interleave();
    clear_beats();
    add_burst(0, 3);
    add_burst(1, 3);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(exp_beat(0, k));
      exp_q.push_back(exp_beat(1, k));
    end
    for (int c = 0; c < 8; c++) begin
      buf_full = (c == 2 || c == 3);
      step();
      checks++;
      if (buf_full) begin
        if (obs_valid !== 1'b0 || obs_ready !== '0 || obs_data !== beat_data(0, 1)) begin
          errors++;
          $display("FAIL il_full cycle %0d got valid=%b ready=%b data=%h want 0 0000 %h",
                   c, obs_valid, obs_ready, obs_data, beat_data(0, 1));
        end
      end else if (obs_fire !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL il_fire cycle %0d got %b want 1", c, obs_fire);
      end else begin
        exp_b = exp_q.pop_front();
        if (obs_beat !== exp_b || obs_ba !== 1'b0) begin
          errors++;
          $display("FAIL il_beat cycle %0d got %h ba=%b want %h ba=0", c, obs_beat, obs_ba, exp_b);
        end
      end
    end
    buf_full = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; m_ready = 1'b1; buf_full = 1'b0;
    clear_beats();
    drive_inputs();
    test_reset();
    test_round_robin();
    test_m_ready_stall();
`ifdef R_ARB_BURST_LOCK_EN
    test_burst_lock();
    test_buf_full();
    test_reset_mid_burst();
`else
    test_interleave();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
